ava_pixel_sequencer: RTL and testbench

Parametrised successor to the AVA scan-out path. It generates active-area coordinates, fetches packed indexed pixels from VRAM, resolves each pixel through the palette RAM and streams 24-bit RGB to the pixel FIFO over a valid/ready handshake. Beyond the previous fixed-mode controller, it adds run-time selectable 1/2/4/8 bpp packing, integer power-of-two upscaling, a configurable VRAM base and full backpressure stalling. It sits in the system clock domain between the VRAM/palette read ports and the async pixel FIFO.

---
 rtl/ava_pkg.sv | 29 ++
 rtl/ava_pixel_unpack.sv | 13 +
 rtl/ava_pixel_sequencer.sv | 178 +++++++++++++++++
 tb/tb_ava_pixel_sequencer.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ava_pkg.sv
// Shared types and constants for the AVA pixel scan-out path.
package ava_pkg;

  localparam int PIXEL_WIDTH = 24;

  typedef enum logic [1:0] {
    BPP1 = 2'd0,
    BPP2 = 2'd1,
    BPP4 = 2'd2,
    BPP8 = 2'd3
  } bpp_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_VBLANK = 2'd3
  } seq_state_t;

  function automatic logic [7:0] bpp_mask(input bpp_t bpp);
    case (bpp)
      BPP1:    return 8'h01;
      BPP2:    return 8'h03;
      BPP4:    return 8'h0F;
      default: return 8'hFF;
    endcase
  endfunction

endpackage

// File: rtl/ava_pixel_unpack.sv
// Extracts one LSB-first packed palette index from a 32-bit VRAM word.
module ava_pixel_unpack
  import ava_pkg::*;
(
  input  logic [31:0] i_word,
  input  bpp_t        i_bpp,
  input  logic [4:0]  i_offset,
  output logic [7:0]  o_index
);

  assign o_index = 8'(i_word >> i_offset) & bpp_mask(i_bpp);

endmodule

// File: rtl/ava_pixel_sequencer.sv
// Scan-out sequencer: coordinates -> VRAM fetch -> palette lookup -> RGB stream,
// with a single global stall driven by the output handshake.
module ava_pixel_sequencer
  import ava_pkg::*;
#(
  parameter int H_ACTIVE        = 640,
  parameter int V_ACTIVE        = 480,
  parameter int VRAM_ADDR_WIDTH = 17,
  parameter int PRAM_ADDR_WIDTH = 8,
  parameter int MAX_SCALE_LOG2  = 2,
  parameter int VBLANK_CYCLES   = 16
)(
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       enable,
  input  logic [1:0]                 cfg_bpp,
  input  logic [1:0]                 cfg_scale_log2,
  input  logic [VRAM_ADDR_WIDTH-1:0] cfg_base,
  output logic [VRAM_ADDR_WIDTH-1:0] vram_a,
  output logic                       vram_en,
  input  logic [31:0]                vram_d,
  output logic [PRAM_ADDR_WIDTH-1:0] pram_a,
  output logic                       pram_en,
  input  logic [31:0]                pram_d,
  output logic [PIXEL_WIDTH-1:0]     pix_data,
  output logic                       pix_valid,
  input  logic                       pix_ready,
  output logic                       frame_start,
  output logic                       vblank,
  output logic                       busy
);

  localparam int XW  = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
  localparam int YW  = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
  localparam int VBW = $clog2(VBLANK_CYCLES + 1);

  seq_state_t                 r_state;
  seq_state_t                 w_state_next;
  bpp_t                       r_bpp;
  logic [1:0]                 r_scale;
  logic [VRAM_ADDR_WIDTH-1:0] r_base;
  logic [XW-1:0]              r_x;
  logic [YW-1:0]              r_y;
  logic [VRAM_ADDR_WIDTH-1:0] r_row_off;
  logic [VBW-1:0]             r_vb_cnt;
  logic                       r_s1_valid;
  logic [4:0]                 r_s1_off;
  logic                       r_s2_valid;
  logic                       r_pix_valid;
  logic [PIXEL_WIDTH-1:0]     r_pix_data;
  logic                       r_first;

  logic                       w_advance;
  logic                       w_issue;
  logic                       w_start;
  logic                       w_x_last;
  logic                       w_y_last;
  logic                       w_vb_done;
  logic                       w_last_accept;
  logic                       w_row_step;
  logic [1:0]                 w_bpp_log2;
  logic [31:0]                w_line_bits;
  logic [31:0]                w_scale_mask;
  logic [VRAM_ADDR_WIDTH-1:0] w_stride;
  logic [XW-1:0]              w_xs;
  logic [31:0]                w_bitpos;
  logic [7:0]                 w_index;
  logic                       w_unused_pram;

  assign w_advance     = ~r_pix_valid | pix_ready;
  assign w_issue       = (r_state == ST_ACTIVE) & w_advance;
  assign w_x_last      = (r_x == XW'(H_ACTIVE - 1));
  assign w_y_last      = (r_y == YW'(V_ACTIVE - 1));
  assign w_vb_done     = (r_vb_cnt == VBW'(VBLANK_CYCLES - 1));
  assign w_last_accept = r_pix_valid & pix_ready & ~r_s1_valid & ~r_s2_valid;
  assign w_start       = (r_state != ST_ACTIVE) & (w_state_next == ST_ACTIVE);

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:   if (enable) w_state_next = ST_ACTIVE;
      ST_ACTIVE: if (w_issue && w_x_last && w_y_last) w_state_next = ST_DRAIN;
      ST_DRAIN:  if (w_last_accept) w_state_next = ST_VBLANK;
      ST_VBLANK: if (w_vb_done) w_state_next = enable ? ST_ACTIVE : ST_IDLE;
      default:   w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= ST_IDLE;
      r_vb_cnt <= '0;
    end else begin
      r_state  <= w_state_next;
      r_vb_cnt <= (r_state == ST_VBLANK) ? r_vb_cnt + VBW'(1) : '0;
    end
  end

  // Row base advances incrementally so no ys*stride multiplier is needed;
  // with upscaling it only steps after the last replicated source line.
  assign w_bpp_log2   = r_bpp;
  assign w_line_bits  = (32'(H_ACTIVE) >> r_scale) << w_bpp_log2;
  assign w_stride     = VRAM_ADDR_WIDTH'((w_line_bits + 32'd31) >> 5);
  assign w_scale_mask = (32'd1 << r_scale) - 32'd1;
  assign w_row_step   = ((32'(r_y) & w_scale_mask) == w_scale_mask);
  assign w_xs         = r_x >> r_scale;
  assign w_bitpos     = 32'(w_xs) << w_bpp_log2;

  assign vram_a  = r_base + r_row_off + VRAM_ADDR_WIDTH'(w_bitpos >> 5);
  assign vram_en = w_issue;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_bpp     <= BPP1;
      r_scale   <= '0;
      r_base    <= '0;
      r_x       <= '0;
      r_y       <= '0;
      r_row_off <= '0;
    end else if (w_start) begin
      r_bpp     <= bpp_t'(cfg_bpp);
      r_scale   <= (cfg_scale_log2 > 2'(MAX_SCALE_LOG2)) ? 2'(MAX_SCALE_LOG2) : cfg_scale_log2;
      r_base    <= cfg_base;
      r_x       <= '0;
      r_y       <= '0;
      r_row_off <= '0;
    end else if (w_issue) begin
      if (w_x_last) begin
        r_x <= '0;
        r_y <= w_y_last ? '0 : r_y + YW'(1);
        if (w_row_step) r_row_off <= r_row_off + w_stride;
      end else begin
        r_x <= r_x + XW'(1);
      end
    end
  end

  ava_pixel_unpack u_unpack (
    .i_word   (vram_d),
    .i_bpp    (r_bpp),
    .i_offset (r_s1_off),
    .o_index  (w_index)
  );

  assign pram_a        = r_s1_valid ? PRAM_ADDR_WIDTH'(w_index) : '0;
  assign pram_en       = w_advance & r_s1_valid;
  assign w_unused_pram = &{1'b0, pram_d[31:PIXEL_WIDTH]};

  // All stages share one advance so RAM outputs and stage registers stay aligned.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_s1_valid  <= 1'b0;
      r_s1_off    <= '0;
      r_s2_valid  <= 1'b0;
      r_pix_valid <= 1'b0;
      r_pix_data  <= '0;
    end else if (w_advance) begin
      r_s1_valid  <= w_issue;
      r_s1_off    <= w_bitpos[4:0];
      r_s2_valid  <= r_s1_valid;
      r_pix_valid <= r_s2_valid;
      if (r_s2_valid) r_pix_data <= pram_d[PIXEL_WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_first <= 1'b0;
    else if (w_start) r_first <= 1'b1;
    else if (r_pix_valid && pix_ready) r_first <= 1'b0;
  end

  assign pix_valid   = r_pix_valid;
  assign pix_data    = r_pix_data;
  assign frame_start = r_first & r_pix_valid & pix_ready;
  assign vblank      = (r_state == ST_IDLE) | (r_state == ST_VBLANK);
  assign busy        = (r_state != ST_IDLE);

endmodule

// File: tb/tb_ava_pixel_sequencer.sv
// Scoreboard bench: expected RGB per frame is queued at stimulus time, popped on accept.
module tb_ava_pixel_sequencer;
  import ava_pkg::*;

  localparam int H  = 32;
  localparam int V  = 4;
  localparam int AW = 10;
  localparam int PW = 8;
  localparam int VB = 5;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          enable;
  logic [1:0]    cfg_bpp;
  logic [1:0]    cfg_scale_log2;
  logic [AW-1:0] cfg_base;
  logic [AW-1:0] vram_a;
  logic          vram_en;
  logic [31:0]   vram_d;
  logic [PW-1:0] pram_a;
  logic          pram_en;
  logic [31:0]   pram_d;
  logic [23:0]   pix_data;
  logic          pix_valid;
  logic          pix_ready;
  logic          frame_start;
  logic          vblank;
  logic          busy;

  ava_pixel_sequencer #(
    .H_ACTIVE(H), .V_ACTIVE(V), .VRAM_ADDR_WIDTH(AW), .PRAM_ADDR_WIDTH(PW),
    .MAX_SCALE_LOG2(2), .VBLANK_CYCLES(VB)
  ) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable),
    .cfg_bpp(cfg_bpp), .cfg_scale_log2(cfg_scale_log2), .cfg_base(cfg_base),
    .vram_a(vram_a), .vram_en(vram_en), .vram_d(vram_d),
    .pram_a(pram_a), .pram_en(pram_en), .pram_d(pram_d),
    .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .frame_start(frame_start), .vblank(vblank), .busy(busy)
  );

  always #5 clk = ~clk;

  logic [31:0] vram_mem [0:(1<<AW)-1];
  logic [31:0] pram_mem [0:255];

  always @(posedge clk) begin
    if (vram_en) vram_d <= vram_mem[vram_a];
    if (pram_en) pram_d <= pram_mem[pram_a];
  end

  typedef struct {
    logic [23:0] data;
    logic        first;
    int          x;
    int          y;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [23:0] model_pix(input int x, input int y, input int bpp,
                                            input int scl, input int base);
    int s, b, xs, ys, stride, addr, off, idx;
    s      = (scl > 2) ? 2 : scl;
    b      = 1 << bpp;
    xs     = x >> s;
    ys     = y >> s;
    stride = ((H >> s) * b + 31) / 32;
    addr   = (base + ys * stride + (xs * b) / 32) % (1 << AW);
    off    = (xs * b) % 32;
    idx    = int'((vram_mem[addr] >> off) & ((32'd1 << b) - 32'd1));
    return pram_mem[idx][23:0];
  endfunction

  task automatic push_frame(input int bpp, input int scl, input int base);
    exp_t e;
    for (int y = 0; y < V; y++) begin
      for (int x = 0; x < H; x++) begin
        e.data  = model_pix(x, y, bpp, scl, base);
        e.first = (x == 0 && y == 0);
        e.x     = x;
        e.y     = y;
        sb_q.push_back(e);
      end
    end
  endtask

  // Output monitor: pops on every accepted pixel and checks stall stability.
  logic        hold_pend = 1'b0;
  logic [23:0] hold_data = '0;

  always @(negedge clk) begin
    exp_t e;
    if (!reset_n) begin
      hold_pend <= 1'b0;
    end else begin
      if (hold_pend) begin
        check("hold_valid", 32'(pix_valid), 32'd1);
        check("hold_data", 32'(pix_data), 32'(hold_data));
      end
      if (pix_valid && pix_ready) begin
        check("sb_nonempty", 32'(sb_q.size() != 0), 32'd1);
        if (sb_q.size() != 0) begin
          e = sb_q.pop_front();
          check("pix_data", 32'(pix_data), 32'(e.data));
          check("frame_start", 32'(frame_start), 32'(e.first));
          $display("pix x=%0d y=%0d data=%06h exp=%06h fs=%0d", e.x, e.y, pix_data, e.data, frame_start);
        end
      end
      hold_pend <= pix_valid && !pix_ready;
      hold_data <= pix_data;
    end
  end

  logic rnd_ready   = 1'b0;
  logic ready_force = 1'b1;

  initial begin
    pix_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      pix_ready = rnd_ready ? 1'($urandom_range(0, 1)) : ready_force;
    end
  end

  task automatic wait_fs(input int max_cyc);
    int n;
    n = 0;
    @(negedge clk);
    while (!frame_start && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    check("fs_timeout", 32'(frame_start), 32'd1);
  endtask

  task automatic wait_idle(input int max_cyc);
    int n;
    n = 0;
    @(negedge clk);
    while (busy && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    check("idle_timeout", 32'(busy), 32'd0);
  endtask

  task automatic run_frame(input int bpp, input int scl, input int base, input logic rnd);
    cfg_bpp        = 2'(bpp);
    cfg_scale_log2 = 2'(scl);
    cfg_base       = AW'(base);
    rnd_ready      = rnd;
    push_frame(bpp, scl, base);
    @(posedge clk);
    #1 enable = 1'b1;
    wait_fs(200);
    enable   = 1'b0;
    cfg_bpp  = 2'(bpp ^ 1);
    cfg_base = AW'(base + 7);
    wait_idle(2000);
    check("idle_vblank", 32'(vblank), 32'd1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int cnt;
    for (int i = 0; i < (1 << AW); i++) vram_mem[i] = $urandom;
    vram_mem[0] = 32'h03020100;
    for (int i = 0; i < 256; i++) pram_mem[i] = {8'hA5, 24'(i * 32'h010101)};

    reset_n = 1'b0;
    enable = 1'b0;
    cfg_bpp = 2'd0;
    cfg_scale_log2 = 2'd0;
    cfg_base = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_vblank", 32'(vblank), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_pix_valid", 32'(pix_valid), 32'd0);
    check("rst_vram_en", 32'(vram_en), 32'd0);
    check("rst_pram_en", 32'(pram_en), 32'd0);
    check("rst_pix_data", 32'(pix_data), 32'd0);
    reset_n = 1'b1;

    // 8bpp, ready held high: latency and first pixels, then mid-frame enable/cfg change.
    cfg_bpp = 2'd3;
    cfg_scale_log2 = 2'd0;
    cfg_base = '0;
    push_frame(3, 0, 0);
    @(posedge clk);
    #1 enable = 1'b1;
    @(posedge clk);
    #1;
    check("act_vblank", 32'(vblank), 32'd0);
    check("act_busy", 32'(busy), 32'd1);
    check("lat_c1", 32'(pix_valid), 32'd0);
    @(posedge clk);
    #1 check("lat_c2", 32'(pix_valid), 32'd0);
    @(posedge clk);
    #1 check("lat_c3", 32'(pix_valid), 32'd0);
    @(posedge clk);
    #1 check("lat_c4", 32'(pix_valid), 32'd1);
    wait_fs(20);
    enable = 1'b0;
    cfg_bpp = 2'd0;
    wait_idle(2000);
    check("idle_vblank", 32'(vblank), 32'd1);

    run_frame(0, 0, 'h010, 1'b1);
    run_frame(2, 1, 'h100, 1'b1);

    // Back-to-back frames with re-latched config and wrapping base addresses.
    cfg_bpp = 2'd1;
    cfg_scale_log2 = 2'd3;
    cfg_base = AW'('h3FC);
    rnd_ready = 1'b1;
    push_frame(1, 3, 'h3FC);
    push_frame(3, 0, 'h3F8);
    @(posedge clk);
    #1 enable = 1'b1;
    wait_fs(200);
    cfg_bpp = 2'd3;
    cfg_scale_log2 = 2'd0;
    cfg_base = AW'('h3F8);
    cnt = 0;
    while (!vblank && cnt < 2000) begin
      @(negedge clk);
      cnt++;
    end
    check("vblank_rise", 32'(vblank), 32'd1);
    cnt = 0;
    while (vblank && cnt < 100) begin
      cnt++;
      @(negedge clk);
    end
    check("vblank_len", 32'(cnt), 32'(VB));
    wait_fs(200);
    enable = 1'b0;
    cfg_bpp = 2'd0;
    wait_idle(2000);

    // Asynchronous reset while a pixel is stalled at the output.
    rnd_ready = 1'b0;
    ready_force = 1'b0;
    cfg_bpp = 2'd3;
    cfg_scale_log2 = 2'd0;
    cfg_base = AW'('h020);
    push_frame(3, 0, 'h020);
    @(posedge clk);
    #1 enable = 1'b1;
    cnt = 0;
    @(negedge clk);
    while (!pix_valid && cnt < 50) begin
      @(negedge clk);
      cnt++;
    end
    check("stall_valid", 32'(pix_valid), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    check("arst_pix_valid", 32'(pix_valid), 32'd0);
    check("arst_vblank", 32'(vblank), 32'd1);
    check("arst_busy", 32'(busy), 32'd0);
    sb_q.delete();
    enable = 1'b0;
    ready_force = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;

    run_frame(2, 0, 'h040, 1'b1);

    check("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
